// File: rtl/ptg_pkg.sv
// Shared definitions for pulse_timing_gen: register offsets, CTRL/STATUS bit indices, FSM states.
// Pure declarations: no latency or backpressure of its own.
package ptg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ptg_state_e;

    localparam logic [7:0] OFS_CTRL   = 8'h80;
    localparam logic [7:0] OFS_PERIOD = 8'h84;
    localparam logic [7:0] OFS_FRAMES = 8'h88;
    localparam logic [7:0] OFS_STATUS = 8'h8C;
    localparam logic [7:0] OFS_IRQ_EN = 8'h90;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_CONT      = 2;
    localparam int STAT_DONE      = 0;
    localparam int STAT_BUSY      = 1;
    localparam int STAT_STATE_LSB = 2;
    localparam int STAT_FRAME     = 4;
    localparam int STAT_FD_LSB    = 16;
    localparam int IRQ_DONE       = 0;
    localparam int IRQ_FRAME      = 1;

    // Byte-lane merge over the low half-word; upper lanes are not backed by storage.
    function automatic logic [15:0] wb_merge16(input logic [15:0] old_val,
                                               input logic [31:0] dat,
                                               input logic [3:0]  sel);
        logic [15:0] v;
        v = old_val;
        if (sel[0]) v[7:0]  = dat[7:0];
        if (sel[1]) v[15:8] = dat[15:8];
        return v;
    endfunction

endpackage

// File: rtl/ptg_window.sv
// Per-channel window compare on the shadow edges; handles normal, wrap-around and empty windows.
// Purely combinational (zero latency), no backpressure.
module ptg_window #(
    parameter int CNT_W = 11
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_up,
    input  logic [CNT_W-1:0] i_down,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_hit
);

    logic w_up_ok;
    logic w_dn_ok;
    logic w_rise;
    logic w_before_fall;

    // An edge at or beyond the period never fires: a missing fall keeps the channel high to frame end.
    assign w_up_ok       = i_up < i_period;
    assign w_dn_ok       = i_down < i_period;
    assign w_rise        = w_up_ok && (i_cnt >= i_up);
    assign w_before_fall = !w_dn_ok || (i_cnt < i_down);

    assign o_hit = (i_up < i_down) ? (w_rise && w_before_fall) :
                   (i_up > i_down) ? (w_rise || w_before_fall) : 1'b0;

endmodule

// File: rtl/pulse_timing_gen.sv
// Wishbone-programmable NUM_CH pulse sequencer with frame shadowing; PTG_IRQ_EN adds IRQ_EN/frame flag/irq_o.
// ch_out/frame_sync_o lag the counter by 1 cycle; WB ack 1 cycle after access, never stalls.
module pulse_timing_gen
    import ptg_pkg::*;
#(
    parameter int         NUM_CH      = 8,
    parameter int         CNT_W       = 11,
    parameter logic [3:0] BASE_NIBBLE = 4'h3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [NUM_CH-1:0] ch_out,
    output logic              frame_sync_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              irq_o
);

    logic [CNT_W-1:0] r_up     [NUM_CH];
    logic [CNT_W-1:0] r_down   [NUM_CH];
    logic [CNT_W-1:0] r_s_up   [NUM_CH];
    logic [CNT_W-1:0] r_s_down [NUM_CH];
    logic [CNT_W-1:0] r_period, r_s_period, r_cnt;
    logic [15:0]      r_frames, r_s_frames, r_frames_done;
    logic             r_cont, r_s_cont, r_start_q, r_done, r_fs;
    logic [NUM_CH-1:0] r_ch;
    ptg_state_e       r_state, w_state_nxt;

    logic [7:0]        w_ofs;
    logic              w_access, w_wr, w_rd, w_wr_ctrl, w_clr_wr;
    logic              w_start, w_abort, w_busy, w_run_ok, w_wrap, w_last, w_load, w_done_nxt;
    logic              w_frame_flag;
    logic [CNT_W-1:0]  w_eff_period;
    logic [15:0]       w_eff_frames, w_fd_inc;
    logic [NUM_CH-1:0] w_win;
    logic [31:0]       w_rd_dat;
    logic              w_unused_wb;

    assign w_unused_wb = ^{wbs_adr_i[27:8], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    assign w_ofs     = wbs_adr_i[7:0];
    assign w_access  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:28] == BASE_NIBBLE) && !wbs_ack_o;
    assign w_wr      = w_access && wbs_we_i;
    assign w_rd      = w_access && !wbs_we_i;
    assign w_wr_ctrl = w_wr && (w_ofs == OFS_CTRL) && wbs_sel_i[0];
    assign w_clr_wr  = w_wr && (w_ofs == OFS_STATUS) && wbs_sel_i[0];

    assign w_start      = (w_wr_ctrl && wbs_dat_i[CTRL_START]) || (start_i && !r_start_q);
    assign w_abort      = (w_wr_ctrl && wbs_dat_i[CTRL_ABORT]) || abort_i;
    assign w_busy       = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign w_run_ok     = (r_state == ST_RUN) && !w_abort;
    assign w_eff_period = (r_s_period < CNT_W'(2)) ? CNT_W'(2) : r_s_period;
    assign w_wrap       = r_cnt == (w_eff_period - CNT_W'(1));
    assign w_eff_frames = (r_s_frames == 16'd0) ? 16'd1 : r_s_frames;
    assign w_fd_inc     = r_frames_done + 16'd1;
    assign w_last       = !r_s_cont && (w_fd_inc == w_eff_frames);
    assign w_load       = ((r_state == ST_ARM) && !w_abort) || (w_run_ok && w_wrap && !w_last);
    assign w_done_nxt   = (r_state == ST_DONE) ? 1'b1 :
                          (w_clr_wr && wbs_dat_i[STAT_DONE]) ? 1'b0 : r_done;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_ARM;
            ST_ARM:  w_state_nxt = w_abort ? ST_IDLE : ST_RUN;
            ST_RUN:  begin
                if (w_abort)               w_state_nxt = ST_IDLE;
                else if (w_wrap && w_last) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_up[c]   <= '0;
                r_down[c] <= '0;
            end
            r_period <= '0;
            r_frames <= '0;
            r_cont   <= 1'b0;
        end else if (w_wr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ofs == 8'(8 * c))
                    r_up[c] <= CNT_W'(wb_merge16(16'(r_up[c]), wbs_dat_i, wbs_sel_i));
                if (w_ofs == 8'(8 * c + 4))
                    r_down[c] <= CNT_W'(wb_merge16(16'(r_down[c]), wbs_dat_i, wbs_sel_i));
            end
            if (w_ofs == OFS_PERIOD)
                r_period <= CNT_W'(wb_merge16(16'(r_period), wbs_dat_i, wbs_sel_i));
            if (w_ofs == OFS_FRAMES)
                r_frames <= wb_merge16(r_frames, wbs_dat_i, wbs_sel_i);
            if (w_wr_ctrl)
                r_cont <= wbs_dat_i[CTRL_CONT];
        end
    end

    // Abort freezes the counters so frames_done stays readable after an early stop.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_s_up[c]   <= '0;
                r_s_down[c] <= '0;
            end
            r_s_period    <= '0;
            r_s_frames    <= '0;
            r_s_cont      <= 1'b0;
            r_cnt         <= '0;
            r_frames_done <= '0;
            r_start_q     <= 1'b0;
            r_ch          <= '0;
            r_fs          <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_start_q <= start_i;
            if (w_load) begin
                r_s_up     <= r_up;
                r_s_down   <= r_down;
                r_s_period <= r_period;
                r_s_frames <= r_frames;
                r_s_cont   <= r_cont;
            end
            if ((r_state == ST_ARM) && !w_abort) begin
                r_cnt         <= '0;
                r_frames_done <= '0;
            end else if (w_run_ok) begin
                if (w_wrap) begin
                    r_cnt         <= '0;
                    r_frames_done <= w_fd_inc;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            r_ch   <= w_run_ok ? w_win : '0;
            r_fs   <= w_run_ok && (r_cnt == '0);
            r_done <= w_done_nxt;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_win
        ptg_window #(.CNT_W(CNT_W)) u_win (
            .i_cnt    (r_cnt),
            .i_up     (r_s_up[c]),
            .i_down   (r_s_down[c]),
            .i_period (w_eff_period),
            .o_hit    (w_win[c])
        );
    end

`ifdef PTG_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_frame_flag, r_irq, w_flag_nxt;

    always_comb begin
        w_flag_nxt = r_frame_flag;
        if (w_clr_wr && wbs_dat_i[STAT_FRAME]) w_flag_nxt = 1'b0;
        if (w_run_ok && w_wrap)                w_flag_nxt = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_irq_en     <= '0;
            r_frame_flag <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_frame_flag <= w_flag_nxt;
            if (w_wr && (w_ofs == OFS_IRQ_EN) && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[1:0];
            r_irq <= (r_irq_en[IRQ_DONE] && w_done_nxt) || (r_irq_en[IRQ_FRAME] && w_flag_nxt);
        end
    end

    assign w_frame_flag = r_frame_flag;
    assign irq_o        = r_irq;
`else
    assign w_frame_flag = 1'b0;
    assign irq_o        = 1'b0;
`endif

    always_comb begin
        w_rd_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ofs == 8'(8 * c))     w_rd_dat[CNT_W-1:0] = r_up[c];
            if (w_ofs == 8'(8 * c + 4)) w_rd_dat[CNT_W-1:0] = r_down[c];
        end
        if (w_ofs == OFS_CTRL)   w_rd_dat[CTRL_CONT]   = r_cont;
        if (w_ofs == OFS_PERIOD) w_rd_dat[CNT_W-1:0]   = r_period;
        if (w_ofs == OFS_FRAMES) w_rd_dat[15:0]        = r_frames;
        if (w_ofs == OFS_STATUS) begin
            w_rd_dat[STAT_FD_LSB +: 16]  = r_frames_done;
            w_rd_dat[STAT_FRAME]         = w_frame_flag;
            w_rd_dat[STAT_STATE_LSB +: 2] = r_state;
            w_rd_dat[STAT_BUSY]          = w_busy;
            w_rd_dat[STAT_DONE]          = r_done;
        end
`ifdef PTG_IRQ_EN
        if (w_ofs == OFS_IRQ_EN) w_rd_dat[1:0] = r_irq_en;
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= w_access;
            wbs_dat_o <= w_rd ? w_rd_dat : '0;
        end
    end

    assign ch_out       = r_ch;
    assign frame_sync_o = r_fs;
    assign busy_o       = w_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_pulse_timing_gen.sv
// Directed bench for pulse_timing_gen: reset, window shapes, shadowing, abort, WB lanes/decode, boundaries.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_pulse_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic        start = 1'b0, abort = 1'b0;
    logic [7:0]  ch_out;
    logic        fs, busy, done, irq;

    int checks = 0;
    int errors = 0;

`ifdef PTG_IRQ_EN
    localparam logic [31:0] FLG = 32'h0000_0010;
`else
    localparam logic [31:0] FLG = 32'h0000_0000;
`endif

    pulse_timing_gen #(.NUM_CH(8), .CNT_W(11), .BASE_NIBBLE(4'h3)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat_o),
        .start_i      (start),
        .abort_i      (abort),
        .ch_out       (ch_out),
        .frame_sync_o (fs),
        .busy_o       (busy),
        .done_o       (done),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle where ack is visible; gives up after 4 edges.
    task automatic wb_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic w, output logic [31:0] rd, output logic acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack) begin
                acked = 1'b1;
                rd = rdat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        acked;
        wb_cycle(a, d, s, 1'b1, rd, acked);
        check("wr_ack", 32'(acked), 32'd1);
    endtask

    task automatic wb_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        acked;
        wb_cycle(a, 32'h0, 4'hF, 1'b0, rd, acked);
        check(tag, acked ? rd : 32'hDEAD_BEEF, exp);
    endtask

    logic [31:0] v_ch0, v_ch1, v_ch2, v_fs, v_busy, v_done;
    logic [31:0] rd_tmp;
    logic        acked_tmp;
    int          done_k, irq_k;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ch_out", 32'(ch_out), 32'h0);
        check("rst_flags", 32'({fs, busy, done, irq, ack}), 32'h0);
        check("rst_dat_o", rdat_o, 32'h0);
        rst_n = 1'b1;
        tick();
        wb_rd_chk("rst_status", 32'h3000_008C, 32'h0);

        // Two one-shot frames: normal, wrap-around and empty windows.
        wb_wr(32'h3000_0000, 32'd2,  4'b0011);
        wb_wr(32'h3000_0004, 32'd5,  4'b0011);
        wb_wr(32'h3000_0008, 32'd8,  4'b0011);
        wb_wr(32'h3000_000C, 32'd2,  4'b0011);
        wb_wr(32'h3000_0010, 32'd4,  4'b0011);
        wb_wr(32'h3000_0014, 32'd4,  4'b0011);
        wb_wr(32'h3000_0084, 32'd10, 4'b0011);
        wb_wr(32'h3000_0088, 32'd2,  4'b0011);
        wb_wr(32'h3000_0080, 32'h1,  4'b0001);
        v_ch0 = '0; v_ch1 = '0; v_ch2 = '0; v_fs = '0; v_busy = '0; v_done = '0;
        for (int k = 2; k <= 25; k++) begin
            tick();
            v_ch0[k]  = ch_out[0];
            v_ch1[k]  = ch_out[1];
            v_ch2[k]  = ch_out[2];
            v_fs[k]   = fs;
            v_busy[k] = busy;
            v_done[k] = done;
        end
        check("seq_ch0", v_ch0, 32'h0003_80E0);
        check("seq_ch1_wrap", v_ch1, 32'h0060_7818);
        check("seq_ch2_empty", v_ch2, 32'h0);
        check("seq_frame_sync", v_fs, 32'h0000_2008);
        check("seq_busy", v_busy, 32'h003F_FFFC);
        check("seq_done", v_done, 32'h0380_0000);
        wb_rd_chk("seq_status", 32'h3000_008C, 32'h0002_0001 | FLG);

        // Continuous run, mid-frame UP[0] rewrite, then external abort.
        wb_wr(32'h3000_008C, 32'h1, 4'b0001);
        check("done_cleared", 32'(done), 32'h0);
        wb_wr(32'h3000_0080, 32'h5, 4'b0001);
        v_ch0 = '0;
        for (int k = 2; k <= 25; k++) begin
            tick();
            v_ch0[k] = ch_out[0];
            if (k == 4) begin
                cyc = 1'b1; stb = 1'b1; we = 1'b1;
                adr = 32'h3000_0000; wdat = 32'd6; sel = 4'b0011;
            end
            if (k == 5) begin
                check("mid_wr_ack", 32'(ack), 32'h1);
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end
            if (k == 6) check("ack_single_cycle", 32'(ack), 32'h0);
        end
        check("shadow_ch0", v_ch0, 32'h03FB_E0E0);
        abort = 1'b1;
        tick();
        check("abort_outputs", 32'({ch_out, fs, busy, done}), 32'h0);
        abort = 1'b0;
        wb_rd_chk("abort_status", 32'h3000_008C, 32'h0002_0000 | FLG);
        wb_wr(32'h3000_0080, 32'h0, 4'b0001);

        // Byte lanes, base-nibble decode, unmapped reads.
        wb_wr(32'h3000_0084, 32'h0000_030A, 4'b0011);
        wb_wr(32'h3000_0084, 32'h0000_01FF, 4'b0001);
        wb_rd_chk("period_lane0", 32'h3000_0084, 32'h0000_03FF);
        wb_cycle(32'h2000_0084, 32'h5, 4'hF, 1'b1, rd_tmp, acked_tmp);
        check("bad_base_no_ack", 32'(acked_tmp), 32'h0);
        wb_rd_chk("bad_base_no_write", 32'h3000_0084, 32'h0000_03FF);
        wb_rd_chk("unmapped_fc", 32'h3000_00FC, 32'h0);
        wb_wr(32'h3000_0088, 32'hFFFF_0000, 4'b1100);
        wb_rd_chk("frames_upper_lanes", 32'h3000_0088, 32'h0000_0002);

        // PERIOD=0 (effective 2) with FRAMES=0: one frame, started by start_i edge.
        wb_wr(32'h3000_0084, 32'h0, 4'b0011);
        wb_wr(32'h3000_0088, 32'h0, 4'b0011);
        done_k = 0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done && done_k == 0) done_k = k;
        end
        check("frames0_done_cycle", 32'(done_k), 32'd5);
        check("start_level_no_retrigger", 32'(busy), 32'h0);
        start = 1'b0;
        wb_rd_chk("frames0_status", 32'h3000_008C, 32'h0001_0001 | FLG);

`ifdef PTG_IRQ_EN
        wb_wr(32'h3000_008C, 32'h11, 4'b0001);
        wb_wr(32'h3000_0090, 32'h1, 4'b0001);
        check("irq_idle_low", 32'(irq), 32'h0);
        wb_wr(32'h3000_0080, 32'h1, 4'b0001);
        irq_k = 0;
        for (int k = 2; k <= 10; k++) begin
            tick();
            if (irq && irq_k == 0) irq_k = k;
        end
        check("irq_at_done", 32'(irq_k), 32'd5);
        wb_rd_chk("irq_en_read", 32'h3000_0090, 32'h1);
        wb_wr(32'h3000_008C, 32'h1, 4'b0001);
        check("irq_cleared", 32'(irq), 32'h0);
`else
        irq_k = 0;
        wb_rd_chk("irq_en_absent", 32'h3000_0090, 32'h0);
        check("irq_tied_low", 32'(irq) + 32'(irq_k), 32'h0);
`endif

        // Asynchronous reset in the middle of a continuous run.
        wb_wr(32'h3000_0084, 32'd10, 4'b0011);
        wb_wr(32'h3000_0080, 32'h5, 4'b0001);
        repeat (3) tick();
        check("pre_reset_ch0", 32'(ch_out[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ch_out", 32'(ch_out), 32'h0);
        check("async_rst_flags", 32'({fs, busy, done, irq, ack}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wb_rd_chk("post_rst_period", 32'h3000_0084, 32'h0);
        wb_rd_chk("post_rst_up0", 32'h3000_0000, 32'h0);
        wb_rd_chk("post_rst_status", 32'h3000_008C, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
